// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: operands in over valid/ready, result out over valid/ready.
// Each REDUCE step subtracts and strips all trailing zeros of the difference in one cycle.
module gcd_stein #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(2*WIDTH)+1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic [CW-1:0]    cycles_o,
  output logic             busy_o
);

  localparam int KW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, INIT, REDUCE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    cnt_q;

  // Index of the lowest set bit; an all-zero input yields WIDTH.
  function automatic logic [KW-1:0] ctz(input logic [WIDTH-1:0] v);
    ctz = KW'(WIDTH);
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (v[i]) ctz = KW'(i);
    end
  endfunction

  logic [KW-1:0]    ctz_a, ctz_b, ctz_d, k_min;
  logic [WIDTH-1:0] diff;
  logic             a_gt_b, a_eq_b, any_zero;

  assign a_gt_b   = a_q > b_q;
  assign a_eq_b   = a_q == b_q;
  assign any_zero = (a_q == '0) || (b_q == '0);
  assign diff     = a_gt_b ? (a_q - b_q) : (b_q - a_q);
  assign ctz_a    = ctz(a_q);
  assign ctz_b    = ctz(b_q);
  assign ctz_d    = ctz(diff);
  assign k_min    = (ctz_a < ctz_b) ? ctz_a : ctz_b;

  assign gcd_o    = gcd_q;
  assign cycles_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = INIT;
      end
      INIT: begin
        busy_o  = 1'b1;
        state_d = any_zero ? DONE : REDUCE;
      end
      REDUCE: begin
        busy_o = 1'b1;
        if (a_eq_b) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, shift and result registers; gcd_q and cnt_q hold steady through DONE and IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      gcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            cnt_q <= '0;
          end
        end
        INIT: begin
          if (a_q == '0) begin
            gcd_q <= b_q;
          end else if (b_q == '0) begin
            gcd_q <= a_q;
          end else begin
            a_q <= a_q >> ctz_a;
            b_q <= b_q >> ctz_b;
            k_q <= k_min;
          end
        end
        REDUCE: begin
          cnt_q <= cnt_q + CW'(1);
          if (a_eq_b)      gcd_q <= a_q << k_q;
          else if (a_gt_b) a_q   <= diff >> ctz_d;
          else             b_q   <= diff >> ctz_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein: literal expectations per operation plus a
// per-cycle monitor that checks every valid result against an arithmetic GCD model.
module tb_gcd_stein;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(2*WIDTH)+1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_i, ready_i;
  logic [WIDTH-1:0] a, b;
  logic             ready_o, valid_o, busy_o;
  logic [WIDTH-1:0] gcd_o;
  logic [CW-1:0]    cycles_o;

  gcd_stein #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a),
    .b_i     (b),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .gcd_o   (gcd_o),
    .cycles_o(cycles_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cyc  = 0;
  logic [WIDTH-1:0] pend_a[$];
  logic [WIDTH-1:0] pend_b[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Euclid's algorithm: an independent route to the GCD.
  function automatic logic [WIDTH-1:0] model_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p = x;
    longint q = y;
    longint t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return WIDTH'(p);
  endfunction

  // Number of odd-odd subtract steps (counting the final equality step).
  function automatic int model_iters(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p = x;
    longint q = y;
    int n = 0;
    if (x == 0 || y == 0) return 0;
    while (p % 2 == 0) p = p / 2;
    while (q % 2 == 0) q = q / 2;
    while (p != q) begin
      n++;
      if (p > q) begin
        p = p - q;
        while (p % 2 == 0) p = p / 2;
      end else begin
        q = q - p;
        while (q % 2 == 0) q = q / 2;
      end
    end
    return n + 1;
  endfunction

  // Monitor: record accepted operand pairs and check every cycle a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_a.delete();
      pend_b.delete();
    end else begin
      if (valid_o) begin
        if (pend_a.size() == 0) begin
          checkOutput("unexpected_valid", 64'd1, 64'd0);
        end else begin
          checkOutput("model_gcd", 64'(gcd_o), 64'(model_gcd(pend_a[0], pend_b[0])));
          checkOutput("model_cycles", 64'(cycles_o), 64'(model_iters(pend_a[0], pend_b[0])));
          if (ready_i) begin
            void'(pend_a.pop_front());
            void'(pend_b.pop_front());
          end
        end
      end
      if (valid_i && ready_o) begin
        pend_a.push_back(a);
        pend_b.push_back(b);
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bit got = 0;
    @(posedge clk); #1;
    valid_i = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [WIDTH-1:0] exp_g,
                            input int exp_c, input int exp_lat);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({name, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
      checkOutput({name, "_gcd"}, 64'(gcd_o), 64'(exp_g));
      checkOutput({name, "_cycles"}, 64'(cycles_o), 64'(exp_c));
      if (ready_i) begin
        @(negedge clk);
        checkOutput({name, "_ready_after"}, 64'(ready_o), 64'd1);
        checkOutput({name, "_valid_after"}, 64'(valid_o), 64'd0);
      end
    end
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] exp_g, input int exp_c, input int exp_lat);
    applyStimulus(av, bv);
    checkOutput({name, "_busy_init"}, 64'(busy_o), 64'd1);
    checkOutput({name, "_ready_init"}, 64'(ready_o), 64'd0);
    waitResult(name, exp_g, exp_c, exp_lat);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a       = '0;
    b       = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_gcd", 64'(gcd_o), 64'd0);
    checkOutput("rst_cycles", 64'(cycles_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    checkOutput("pin_model_gcd_48_180", 64'(model_gcd(48, 180)), 64'd12);
    checkOutput("pin_model_iters_48_180", 64'(model_iters(48, 180)), 64'd4);
    checkOutput("pin_model_iters_ffff_1", 64'(model_iters(32'hFFFF_FFFF, 1)), 64'd32);
    checkOutput("pin_model_gcd_0_0", 64'(model_gcd(0, 0)), 64'd0);

    runOp("g12_18", 12, 18, 6, 2, 4);
    runOp("g48_180", 48, 180, 12, 4, 6);
    runOp("g0_25", 0, 25, 25, 0, 2);
    runOp("g25_0", 25, 0, 25, 0, 2);
    runOp("g0_0", 0, 0, 0, 0, 2);
    runOp("g_msb", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1, 3);
    runOp("g_ones_1", 32'hFFFF_FFFF, 1, 1, 32, 34);

    // Backpressure: result held while a new pair waits on valid_i.
    ready_i = 1'b0;
    applyStimulus(21, 14);
    waitResult("bp_first", 7, 2, 4);
    @(posedge clk); #1;
    valid_i = 1'b1;
    a = 100;
    b = 75;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid_hold", 64'(valid_o), 64'd1);
      checkOutput("bp_gcd_hold", 64'(gcd_o), 64'd7);
      checkOutput("bp_cycles_hold", 64'(cycles_o), 64'd2);
      checkOutput("bp_ready_low", 64'(ready_o), 64'd0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_still_done", 64'(valid_o), 64'd1);
    @(negedge clk);
    checkOutput("bp_idle_ready", 64'(ready_o), 64'd1);
    checkOutput("bp_idle_valid", 64'(valid_o), 64'd0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
    waitResult("bp_next", 25, 2, 4);

    // Asynchronous abort in the middle of a long reduction.
    applyStimulus(32'hFFFF_FFFF, 1);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 64'(busy_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 64'(valid_o), 64'd0);
    checkOutput("abort_busy", 64'(busy_o), 64'd0);
    checkOutput("abort_ready", 64'(ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    runOp("g9_6", 9, 6, 3, 2, 4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
